// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the two-entry pipeline skid register.
// Provides the occupancy state encoding and a state-to-level decode helper.
package pipe_skid_reg_pkg;

    localparam int unsigned LEVEL_W = 2;
    localparam int unsigned STATE_W = 2;

    // Occupancy state; the encoding is fixed so level can be read straight off it.
    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

    // Number of held entries for a given state.
    function automatic logic [LEVEL_W-1:0] state_level(input skid_state_e st);
        logic [LEVEL_W-1:0] lv;
        lv = LEVEL_W'(0);
        case (st)
            ST_ONE:  lv = LEVEL_W'(1);
            ST_TWO:  lv = LEVEL_W'(2);
            default: lv = LEVEL_W'(0);
        endcase
        return lv;
    endfunction

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg_dffe_sr.sv
// WIDTH-bit data register with load enable, synchronous active-low clear and
// synchronous flush clear; both clears load RESET_VAL.
// Ports:
//   clk   - clock
//   clrn  - synchronous active-low clear (highest priority)
//   flush - synchronous clear (below clrn, above en)
//   en    - load enable
//   d     - next value
//   q     - registered value
module dffe_sr #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over flush, flush over load.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            q <= RESET_VAL;
        end else if (flush) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : dffe_sr

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages (main + skid register).
// Sustains one transfer per cycle while in_ready depends only on registered
// state, breaking the combinational ready path from downstream.
// Ports:
//   clk       - clock
//   clrn      - synchronous active-low reset
//   flush     - synchronous discard of all held entries
//   in_valid  - upstream presents in_data
//   in_ready  - block can accept (registered)
//   in_data   - upstream payload
//   out_valid - out_data is valid (registered)
//   out_ready - downstream accepts
//   out_data  - payload, straight from the main register
//   level     - occupancy 0..2 (registered)
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [LEVEL_W-1:0] level
);

    skid_state_e      state;
    skid_state_e      state_nxt;
    logic             in_acc;
    logic             out_acc;
    logic             main_en;
    logic             main_from_skid;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;
    assign main_d  = main_from_skid ? skid_q : in_data;

    // State register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and data-path steering.
    always_comb begin
        state_nxt      = state;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_acc) begin
                    state_nxt = ST_ONE;
                    main_en   = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_acc && out_acc) begin
                    main_en = 1'b1;
                end else if (in_acc) begin
                    // Downstream stalled: park the new word behind the main entry.
                    state_nxt = ST_TWO;
                    skid_en   = 1'b1;
                end else if (out_acc) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_acc) begin
                    state_nxt      = ST_ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        // Flush wins over normal operation; the data registers clear themselves.
        if (flush) begin
            state_nxt = ST_EMPTY;
        end
    end

    // Handshake and occupancy outputs, registered from the next state so they
    // always mirror the state register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            level     <= LEVEL_W'(0);
        end else begin
            in_ready  <= (state_nxt != ST_TWO);
            out_valid <= (state_nxt != ST_EMPTY);
            level     <= state_level(state_nxt);
        end
    end

    dffe_sr #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .clrn  (clrn),
        .flush (flush),
        .en    (main_en),
        .d     (main_d),
        .q     (out_data)
    );

    dffe_sr #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .clrn  (clrn),
        .flush (flush),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule : pipe_skid_reg
